// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-channel valid/ready stream multiplexer with fixed-select and round-robin modes
// One-entry registered output stage; in_ready is combinational from mode, select, valids and state.
module stream_mux #(
   parameter int WIDTH = 8,
   parameter int N     = 8,
   parameter int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   input  logic               rr_en,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_grant
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  chosen;
   logic [SELW-1:0]  hi_idx;
   logic [SELW-1:0]  any_idx;
   logic [SELW-1:0]  next_ptr;
   logic             chosen_vld;
   logic             found_hi;
   logic             found_any;
   logic             load_ok;
   logic             xfer;
   logic             pop;
   logic             sel_valid;
   logic [WIDTH-1:0] sel_data;

   // Lowest valid channel at or above ptr wins; otherwise wrap to the lowest valid channel overall.
   always_comb begin
      hi_idx    = '0;
      any_idx   = '0;
      found_hi  = 1'b0;
      found_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            any_idx   = SELW'(i);
            found_any = 1'b1;
            if (i >= int'(ptr)) begin
               hi_idx   = SELW'(i);
               found_hi = 1'b1;
            end
         end
      end
   end

   always_comb begin
      chosen     = '0;
      chosen_vld = 1'b0;
      if (rr_en) begin
         chosen     = found_hi ? hi_idx : any_idx;
         chosen_vld = found_any;
      end else begin
         chosen     = sel;
         chosen_vld = (int'(sel) < N);
      end
   end

   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (chosen == SELW'(i)) begin
            sel_data  = in_data[i*WIDTH +: WIDTH];
            sel_valid = in_valid[i];
         end
      end
   end

   // Gating with reset_n keeps every in_ready low while reset is held.
   assign load_ok  = reset_n && (!out_valid || out_ready);
   assign xfer     = load_ok && chosen_vld && sel_valid;
   assign pop      = out_valid && out_ready;
   assign next_ptr = (chosen == SELW'(N - 1)) ? '0 : chosen + SELW'(1);

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = load_ok && chosen_vld && (chosen == SELW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_grant <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_grant <= chosen;
         ptr       <= next_ptr;
      end else if (pop) begin
         out_valid <= 1'b0;
      end
   end

endmodule
